// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm sequencing controller: state encoding,
// time field widths and the alarm time-match helper.
package alarm_ctrl_pkg;

    localparam int HH_W = 5;
    localparam int MM_W = 6;
    localparam int SS_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    // Exact binary compare; out-of-range times simply never match.
    function automatic logic time_match(
        input logic [HH_W-1:0] cur_hh,
        input logic [MM_W-1:0] cur_mm,
        input logic [SS_W-1:0] cur_ss,
        input logic [HH_W-1:0] alarm_hh,
        input logic [MM_W-1:0] alarm_mm
    );
        return (cur_hh == alarm_hh) && (cur_mm == alarm_mm) && (cur_ss == '0);
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced, synchronized button level.
// One pulse per press, no matter how long the button is held.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_btn;
        end
    end

    assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: triggers on the programmed minute, then runs
// the ring / snooze / stop sequence, all timed in 1 Hz ticks.
module alarm_ctrl
    import alarm_ctrl_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick_1hz,
    input  logic [HH_W-1:0] cur_hh,
    input  logic [MM_W-1:0] cur_mm,
    input  logic [SS_W-1:0] cur_ss,
    input  logic [HH_W-1:0] alarm_hh,
    input  logic [MM_W-1:0] alarm_mm,
    input  logic            alarm_en,
    input  logic            snooze_btn,
    input  logic            stop_btn,
    output logic            alert,
    output logic            snoozing,
    output logic [1:0]      snooze_used,
    output logic            missed
);

    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);
    localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_MIN * 60 - 1);
    localparam logic [1:0] MAX_SNZ   = 2'(MAX_SNOOZE);

    state_t     r_state;
    logic [7:0] r_ring_cnt;
    logic [9:0] r_snz_cnt;
    logic [1:0] r_snooze_used;
    logic       r_missed;
    logic       r_alert;
    logic       r_snoozing;

    state_t     w_state_next;
    logic [7:0] w_ring_next;
    logic [9:0] w_snz_next;
    logic [1:0] w_used_next;
    logic       w_missed_next;
    logic       w_snz_rise;
    logic       w_stop_rise;
    logic       w_match;

    btn_edge u_snooze_edge (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (snooze_btn),
        .o_rise (w_snz_rise)
    );

    btn_edge u_stop_edge (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (stop_btn),
        .o_rise (w_stop_rise)
    );

    assign w_match = tick_1hz && time_match(cur_hh, cur_mm, cur_ss, alarm_hh, alarm_mm);

    // Disarm beats stop, stop beats snooze, snooze beats any tick-driven move.
    always_comb begin
        w_state_next  = r_state;
        w_ring_next   = r_ring_cnt;
        w_snz_next    = r_snz_cnt;
        w_used_next   = r_snooze_used;
        w_missed_next = r_missed;

        if (!alarm_en) begin
            w_state_next  = ST_IDLE;
            w_missed_next = 1'b0;
        end else if (w_stop_rise) begin
            w_state_next  = ST_IDLE;
            w_missed_next = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_match) begin
                        w_state_next  = ST_RINGING;
                        w_ring_next   = 8'd0;
                        w_used_next   = 2'd0;
                        w_missed_next = 1'b0;
                    end
                end
                ST_RINGING: begin
                    if (w_snz_rise && (r_snooze_used < MAX_SNZ)) begin
                        w_state_next = ST_SNOOZE;
                        w_snz_next   = SNZ_LOAD;
                        w_used_next  = r_snooze_used + 2'd1;
                    end else if (tick_1hz) begin
                        if (r_ring_cnt == RING_LAST) begin
                            w_state_next  = ST_IDLE;
                            w_missed_next = 1'b1;
                        end else begin
                            w_ring_next = r_ring_cnt + 8'd1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (tick_1hz) begin
                        if (r_snz_cnt == 10'd0) begin
                            w_state_next = ST_RINGING;
                            w_ring_next  = 8'd0;
                        end else begin
                            w_snz_next = r_snz_cnt - 10'd1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Flag outputs are decoded from the next state so they stay registered
    // yet line up exactly with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_ring_cnt    <= 8'd0;
            r_snz_cnt     <= 10'd0;
            r_snooze_used <= 2'd0;
            r_missed      <= 1'b0;
            r_alert       <= 1'b0;
            r_snoozing    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ring_cnt    <= w_ring_next;
            r_snz_cnt     <= w_snz_next;
            r_snooze_used <= w_used_next;
            r_missed      <= w_missed_next;
            r_alert       <= (w_state_next == ST_RINGING);
            r_snoozing    <= (w_state_next == ST_SNOOZE);
        end
    end

    assign alert       = r_alert;
    assign snoozing    = r_snoozing;
    assign snooze_used = r_snooze_used;
    assign missed      = r_missed;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl with 5 min snooze,
// 60 s ring timeout and up to 3 snoozes.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [4:0] cur_hh = '0;
    logic [5:0] cur_mm = '0;
    logic [5:0] cur_ss = '0;
    logic [4:0] alarm_hh = 5'd7;
    logic [5:0] alarm_mm = 6'd30;
    logic       alarm_en = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       alert;
    logic       snoozing;
    logic [1:0] snooze_used;
    logic       missed;

    int checks = 0;
    int failures = 0;

    alarm_ctrl #(
        .SNOOZE_MIN     (5),
        .RING_TIMEOUT_S (60),
        .MAX_SNOOZE     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .cur_hh      (cur_hh),
        .cur_mm      (cur_mm),
        .cur_ss      (cur_ss),
        .alarm_hh    (alarm_hh),
        .alarm_mm    (alarm_mm),
        .alarm_en    (alarm_en),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .alert       (alert),
        .snoozing    (snoozing),
        .snooze_used (snooze_used),
        .missed      (missed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            cyc();
            tick_1hz = 1'b0;
            cyc();
        end
    endtask

    task automatic set_time(input int hh, input int mm, input int ss);
        cur_hh = 5'(hh);
        cur_mm = 6'(mm);
        cur_ss = 6'(ss);
    endtask

    // Tick at 07:30:00, then move the seconds on so it cannot match again.
    task automatic trigger();
        set_time(7, 30, 0);
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        set_time(7, 30, 1);
    endtask

    task automatic press_snooze();
        snooze_btn = 1'b1;
        cyc();
    endtask

    task automatic release_btns();
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        cyc();
    endtask

    task automatic press_stop();
        stop_btn = 1'b1;
        cyc();
    endtask

    initial begin
        // Reset state
        repeat (3) cyc();
        check("rst_alert", alert, 0);
        check("rst_snoozing", snoozing, 0);
        check("rst_used", snooze_used, 0);
        check("rst_missed", missed, 0);
        rst = 1'b1;
        cyc();

        // Disarmed alarm must not trigger
        trigger();
        check("disarmed_no_trig", alert, 0);
        cyc();
        alarm_en = 1'b1;
        cyc();

        // Near misses
        set_time(7, 29, 0);
        ticks(1);
        check("trig_0729_00", alert, 0);
        set_time(7, 30, 1);
        ticks(1);
        check("trig_0730_01", alert, 0);

        // Trigger visible the cycle after the tick
        trigger();
        $display("trigger: alert=%0d", alert);
        check("trig_alert", alert, 1);
        check("trig_used", snooze_used, 0);
        cyc();

        // Timeout after exactly 60 ticks
        ticks(59);
        check("ring_59_ticks", alert, 1);
        ticks(1);
        $display("timeout: alert=%0d missed=%0d", alert, missed);
        check("timeout_alert", alert, 0);
        check("timeout_missed", missed, 1);
        ticks(3);
        check("no_retrigger", alert, 0);

        // Stop press in IDLE clears missed
        press_stop();
        check("stop_clears_missed", missed, 0);
        release_btns();

        // Snooze three times, fourth ignored
        trigger();
        check("retrig_alert", alert, 1);
        cyc();
        for (int k = 1; k <= 3; k++) begin
            press_snooze();
            $display("snooze %0d: alert=%0d snoozing=%0d used=%0d", k, alert, snoozing, snooze_used);
            check("snz_alert", alert, 0);
            check("snz_snoozing", snoozing, 1);
            check("snz_used", snooze_used, 32'(k));
            release_btns();
            ticks(299);
            check("snz_299_alert", alert, 0);
            check("snz_299_snoozing", snoozing, 1);
            ticks(1);
            check("snz_rering", alert, 1);
            check("snz_rering_snoozing", snoozing, 0);
        end
        press_snooze();
        check("snz4_alert", alert, 1);
        check("snz4_snoozing", snoozing, 0);
        check("snz4_used", snooze_used, 3);
        release_btns();

        // Stop held for 10 cycles during snooze
        press_stop();
        release_btns();
        check("stop_ring_alert", alert, 0);
        trigger();
        check("trig3_used", snooze_used, 0);
        cyc();
        press_snooze();
        release_btns();
        check("hold_pre_snoozing", snoozing, 1);
        stop_btn = 1'b1;
        cyc();
        check("hold_first_snoozing", snoozing, 0);
        check("hold_first_alert", alert, 0);
        repeat (9) cyc();
        ticks(2);
        check("hold_end_snoozing", snoozing, 0);
        check("hold_end_alert", alert, 0);
        release_btns();

        // Stop and snooze together while ringing
        trigger();
        cyc();
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        cyc();
        check("both_alert", alert, 0);
        check("both_snoozing", snoozing, 0);
        release_btns();

        // Disarm mid-ring
        trigger();
        ticks(5);
        alarm_en = 1'b0;
        cyc();
        check("disarm_alert", alert, 0);
        check("disarm_missed", missed, 0);
        alarm_en = 1'b1;
        cyc();

        // Disarm clears a missed flag
        trigger();
        ticks(60);
        check("missed_again", missed, 1);
        alarm_en = 1'b0;
        cyc();
        check("disarm_clears_missed", missed, 0);
        alarm_en = 1'b1;
        cyc();

        // Asynchronous reset mid-snooze, no re-ring afterwards
        trigger();
        cyc();
        press_snooze();
        release_btns();
        ticks(10);
        check("pre_rst_snoozing", snoozing, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_snoozing", snoozing, 0);
        check("async_rst_used", snooze_used, 0);
        check("async_rst_alert", alert, 0);
        cyc();
        rst = 1'b1;
        cyc();
        ticks(310);
        check("no_rering_alert", alert, 0);
        check("no_rering_snoozing", snoozing, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
